demux_8_way_16_bank: RTL and testbench
======================================

Name: demux_8_way_16_bank

Overview:
- Write-side counterpart of the 8-way 16-bit word multiplexer.
- Accepts a stream of 16-bit words through a valid/ready handshake and scatters them into an 8-lane register bank. The lane is chosen by an auto-incrementing pointer, which can be reloaded from an explicit lane select.
- Presents the bank as one packed 128-bit bus with lane k at out[16k+:16], the same lane layout the mux reads. Asserts out_valid once every lane has been written.

Parameters:
- WIDTH, 16, bits per lane.
- LANES, 8, number of lanes; must be a power of two.
- SEL_WIDTH, 3, lane select width; must equal log2(LANES).

Ports:
- clk  input  1  rising-edge clock.
- reset  input  1  synchronous, active-high reset.
- in  input  WIDTH  data word to write.
- in_valid  input  1  in is valid this cycle.
- in_ready  output  1  block accepts a write this cycle.
- sel  input  SEL_WIDTH  lane to load into the write pointer.
- sel_load  input  1  load pointer from sel this cycle.
- out  output  WIDTH*LANES  packed bank; lane k at out[WIDTH*k +: WIDTH].
- out_valid  output  1  all lanes written; bank frozen.
- out_ready  input  1  consumer releases the bank.
- lane_written  output  LANES  per-lane "written since last release" flags.

Behaviour:
- Reset, sampled on the clk edge, sets:
  - out to 0
  - lane_written to 0
  - write pointer ptr to 0
  - state to FILL
  - out_valid to 0
- reset overrides every other input in the same cycle. A write presented alongside reset is dropped. Reset during HOLD discards the bank.
- in_ready = (state == FILL), combinational from state. in_ready is 1 in the first cycle after reset.
- A write occurs when in_valid and in_ready are both 1 at an edge.
- State FILL:
  - Target lane: tgt = sel if sel_load else ptr.
  - On a write:
    - out lane tgt <= in.
    - lane_written[tgt] <= 1.
    - ptr <= tgt + 1, mod LANES (lane 7 wraps to 0).
  - sel_load without a write: ptr <= sel, and nothing else changes.
  - Rewriting an already-written lane overwrites its data; the flags are unchanged.
  - If, after the write, every bit of lane_written is 1, the state moves to HOLD at that same edge, so out_valid = 1 in the next cycle.
  - Write latency: the written data is visible on out in the cycle after the accepting edge.
- State HOLD:
  - out_valid = 1, in_ready = 0.
  - out and lane_written are held stable.
  - in_valid, in, sel and sel_load are ignored; ptr does not change.
  - out_ready = 1 at an edge causes:
    - state <= FILL
    - lane_written <= 0
    - ptr <= 0
    - out_valid falls the next cycle
  - out data is retained (not cleared) after release; only the flags reset.
  - out_ready in FILL has no effect.
- out_valid = (state == HOLD); it is registered state, with no combinational path from any input.
- No path from in to out within the same cycle.
- Completion depends on the flags, not on a count of writes. Eight writes to the same lane never complete. Eight writes starting at any lane with pure auto-increment always complete.

Test Plan:
- Reset then idle:
  - Assert reset 2 cycles, release.
  - Required: out = 0, lane_written = 8'h00, out_valid = 0, in_ready = 1.
- Sequential fill:
  - With sel_load = 0, write 16'h1000+k for k = 0..7 on consecutive cycles.
  - Required: after the 8th edge, out_valid = 1, in_ready = 0, lane_written = 8'hFF, and out[16k+:16] = 16'h1000+k for every k.
  - A 9th word (16'hDEAD) presented in HOLD is not accepted, and out is unchanged.
- Loaded start and wrap:
  - Write with sel_load = 1, sel = 6, in = 16'hA006.
  - Then write 7 more auto-increment words 16'hA007, 16'hA000..16'hA005.
  - Required: ptr wraps 7 -> 0, out_valid = 1 after the 8th write, and lane k holds 16'hA000+k.
- Overwrite without completion:
  - Write lane 3 four times with 16'h0001..16'h0004 via sel_load.
  - Required: lane 3 = 16'h0004, lane_written = 8'h08, out_valid = 0.
- Release and refill:
  - From full HOLD, pulse out_ready 1 cycle.
  - Required: next cycle out_valid = 0, lane_written = 0, in_ready = 1, and old data is still on out.
  - A new write of 16'hBEEF lands in lane 0.
- Randomised check:
  - Run 128 iterations of random in, sel, sel_load and in_valid, with out_ready asserted 1 cycle after out_valid.
  - Check out against a reference model of the 8 lanes and completion every cycle.
  - On any mismatch, $fatal with in, sel, out and expected out.

Source files
------------

// File: rtl/demux_8_way_16_bank.sv
// Write-side lane scatter: accepts a valid/ready word stream and fills an
// 8-lane register bank, then holds the packed bank until the consumer releases it.
module demux_8_way_16_bank #(
  parameter int WIDTH     = 16,
  parameter int LANES     = 8,   // must be a power of two
  parameter int SEL_WIDTH = 3    // must equal log2(LANES)
) (
  input  logic                   clk,
  input  logic                   reset,
  input  logic [WIDTH-1:0]       in,
  input  logic                   in_valid,
  output logic                   in_ready,
  input  logic [SEL_WIDTH-1:0]   sel,
  input  logic                   sel_load,
  output logic [WIDTH*LANES-1:0] out,
  output logic                   out_valid,
  input  logic                   out_ready,
  output logic [LANES-1:0]       lane_written
);

  // Handshakes: a word is taken when in_valid && in_ready at a rising edge;
  // the bank is released when out_valid && out_ready at a rising edge.
  typedef enum logic [0:0] {
    FILL = 1'b0,
    HOLD = 1'b1
  } state_t;

  state_t               state;
  logic [SEL_WIDTH-1:0] ptr;
  logic [SEL_WIDTH-1:0] tgt;
  logic                 write;
  logic [LANES-1:0]     written_next;

  assign in_ready  = (state == FILL);
  assign out_valid = (state == HOLD);
  assign tgt       = sel_load ? sel : ptr;
  assign write     = in_valid && in_ready;

  always_comb begin
    written_next = lane_written;
    for (int k = 0; k < LANES; k++) begin
      if (tgt == SEL_WIDTH'(k)) written_next[k] = 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state        <= FILL;
      ptr          <= '0;
      out          <= '0;
      lane_written <= '0;
    end else begin
      case (state)
        FILL: begin
          if (write) begin
            for (int k = 0; k < LANES; k++) begin
              if (tgt == SEL_WIDTH'(k)) out[k*WIDTH +: WIDTH] <= in;
            end
            lane_written <= written_next;
            ptr          <= tgt + SEL_WIDTH'(1);
            // Completion is driven by the flags, so repeated writes to one lane never finish.
            if (&written_next) state <= HOLD;
          end else if (sel_load) begin
            ptr <= sel;
          end
        end
        HOLD: begin
          // Data stays on out after release; only the flags and pointer restart.
          if (out_ready) begin
            state        <= FILL;
            lane_written <= '0;
            ptr          <= '0;
          end
        end
        default: state <= FILL;
      endcase
    end
  end

endmodule

// File: tb/tb_demux_8_way_16_bank.sv
// Self-checking bench for demux_8_way_16_bank: directed scenarios plus a
// randomised run, all compared against a small lane-bank reference model.
module tb_demux_8_way_16_bank;

  localparam int WIDTH = 16;
  localparam int LANES = 8;
  localparam int SW    = 3;
  localparam int W     = WIDTH * LANES;

  logic             clk = 1'b0;
  logic             reset;
  logic [WIDTH-1:0] in;
  logic             in_valid;
  logic             in_ready;
  logic [SW-1:0]    sel;
  logic             sel_load;
  logic [W-1:0]     out;
  logic             out_valid;
  logic             out_ready;
  logic [LANES-1:0] lane_written;

  demux_8_way_16_bank #(.WIDTH(WIDTH), .LANES(LANES), .SEL_WIDTH(SW)) dut (
    .clk(clk), .reset(reset), .in(in), .in_valid(in_valid), .in_ready(in_ready),
    .sel(sel), .sel_load(sel_load), .out(out), .out_valid(out_valid),
    .out_ready(out_ready), .lane_written(lane_written)
  );

  always #5 clk = ~clk;

  // reference model
  logic [WIDTH-1:0] m_bank [LANES];
  logic [LANES-1:0] m_written;
  logic [SW-1:0]    m_ptr;
  logic             m_hold;

  logic [W-1:0] exp_q[$];
  int checks = 0;
  int errors = 0;

  task automatic check(input string tag, input logic [W-1:0] obs, input logic [W-1:0] exp);
    checks++;
    if (obs !== exp) begin
      errors++;
      $display("FAIL %s got %h expected %h", tag, obs, exp);
    end
  endtask

  function automatic logic [W-1:0] pack_bank();
    logic [W-1:0] p;
    for (int k = 0; k < LANES; k++) p[k*WIDTH +: WIDTH] = m_bank[k];
    return p;
  endfunction

  function automatic logic [WIDTH-1:0] lane_of(input logic [W-1:0] bus, input int k);
    return bus[k*WIDTH +: WIDTH];
  endfunction

  task automatic model_reset();
    for (int k = 0; k < LANES; k++) m_bank[k] = '0;
    m_written = '0;
    m_ptr     = '0;
    m_hold    = 1'b0;
  endtask

  task automatic do_reset();
    reset = 1'b1; in_valid = 1'b1; in = 16'h5555; sel = '0; sel_load = 1'b0; out_ready = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    reset = 1'b0; in_valid = 1'b0;
    model_reset();
    check("rst_out", out, '0);
    check("rst_flags", W'(lane_written), '0);
    check("rst_out_valid", W'(out_valid), '0);
    check("rst_in_ready", W'(in_ready), W'(1));
  endtask

  // drive one cycle, advance the model, push expected bank, compare after edge
  task automatic step(input logic v, input logic [WIDTH-1:0] d, input logic [SW-1:0] s,
                      input logic sl, input logic ordy);
    logic [SW-1:0] t;
    in_valid = v; in = d; sel = s; sel_load = sl; out_ready = ordy;
    if (!m_hold) begin
      t = sl ? s : m_ptr;
      if (v) begin
        m_bank[t]    = d;
        m_written[t] = 1'b1;
        m_ptr        = t + 3'd1;
        if (m_written == {LANES{1'b1}}) m_hold = 1'b1;
      end else if (sl) begin
        m_ptr = s;
      end
    end else if (ordy) begin
      m_hold    = 1'b0;
      m_written = '0;
      m_ptr     = '0;
    end
    exp_q.push_back(pack_bank());
    @(posedge clk);
    #1;
    in_valid = 1'b0; sel_load = 1'b0; out_ready = 1'b0;
    check("out", out, exp_q.pop_front());
    check("flags", W'(lane_written), W'(m_written));
    check("out_valid", W'(out_valid), W'(m_hold));
    check("in_ready", W'(in_ready), W'(!m_hold));
  endtask

  initial begin
    logic [W-1:0] snap;
    int errs_before;
    logic [WIDTH-1:0] rd;
    logic [SW-1:0] rs;
    logic rsl, rv;

    do_reset();

    // sequential fill
    for (int k = 0; k < LANES; k++) step(1'b1, 16'h1000 + WIDTH'(k), '0, 1'b0, 1'b0);
    check("seq_out_valid", W'(out_valid), W'(1));
    check("seq_in_ready", W'(in_ready), '0);
    check("seq_flags", W'(lane_written), W'(8'hFF));
    for (int k = 0; k < LANES; k++) check("seq_lane", W'(lane_of(out, k)), W'(16'h1000 + k));
    snap = out;
    step(1'b1, 16'hDEAD, '0, 1'b0, 1'b0);
    check("hold_ignores_write", out, snap);

    // release and refill
    step(1'b0, '0, '0, 1'b0, 1'b1);
    check("rel_out_valid", W'(out_valid), '0);
    check("rel_flags", W'(lane_written), '0);
    check("rel_in_ready", W'(in_ready), W'(1));
    check("rel_data_kept", out, snap);
    step(1'b1, 16'hBEEF, '0, 1'b0, 1'b0);
    check("refill_lane0", W'(lane_of(out, 0)), W'(16'hBEEF));

    // loaded start at lane 6 with wrap
    do_reset();
    step(1'b1, 16'hA006, 3'd6, 1'b1, 1'b0);
    step(1'b1, 16'hA007, '0, 1'b0, 1'b0);
    for (int k = 0; k < 6; k++) step(1'b1, 16'hA000 + WIDTH'(k), '0, 1'b0, 1'b0);
    check("wrap_out_valid", W'(out_valid), W'(1));
    for (int k = 0; k < LANES; k++) check("wrap_lane", W'(lane_of(out, k)), W'(16'hA000 + k));
    step(1'b0, '0, '0, 1'b0, 1'b1);

    // overwrite one lane without completing
    for (int k = 1; k <= 4; k++) step(1'b1, WIDTH'(k), 3'd3, 1'b1, 1'b0);
    check("ovw_lane3", W'(lane_of(out, 3)), W'(16'h0004));
    check("ovw_flags", W'(lane_written), W'(8'h08));
    check("ovw_out_valid", W'(out_valid), '0);

    // randomised run; out_ready follows out_valid by one cycle
    do_reset();
    for (int i = 0; i < 128; i++) begin
      rd  = WIDTH'($urandom_range(0, 16'hFFFF));
      rs  = SW'($urandom_range(0, LANES - 1));
      rsl = ($urandom_range(0, 3) == 0);
      rv  = ($urandom_range(0, 3) != 0);
      errs_before = errors;
      step(rv, rd, rs, rsl, m_hold);
      if (errors != errs_before) begin
        $display("FAIL rand iter %0d in=%h sel=%0d out=%h exp=%h", i, rd, rs, out, pack_bank());
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $fatal(1, "random mismatch in=%h sel=%0d out=%h expected=%h", rd, rs, out, pack_bank());
      end
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
